fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side companion for the team's synchronous FIFO: drains words through its `rd`/`empty`/`dout` interface and presents them as a valid/ready stream with packet framing. It absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one word per cycle under continuous downstream ready. It sits between a FIFO instance and any stream consumer (serializer, DMA, packet sink).

## Interface
- `width`, 8, data word width; must equal the connected FIFO's `width`.
- `pkt_len`, 4, words per packet (≥1); sets the `m_last` cadence.
- `clk` input 1 rising-edge clock, shared with the FIFO.
- `rst` input 1 reset; one clock; reset is synchronous and active-high.
- `en` input 1 allow new FIFO reads; does not gate delivery of already-fetched words.
- `fifo_empty` input 1 FIFO `empty`.
- `fifo_dout` input width FIFO `dout`; valid the cycle after an accepted `fifo_rd`.
- `fifo_rd` output 1 FIFO `rd` request (combinational).
- `m_valid` output 1 output word available.
- `m_data` output width output word (registered).
- `m_last` output 1 final word of the current packet; qualified by `m_valid`.
- `m_ready` input 1 consumer accepts the word when high with `m_valid`.

## Operation
- State: `pending` (1 bit: read issued last cycle), 2-entry buffer with `count` 0..2, head/tail index, `beat` counter of `$clog2(pkt_len)` bits (min 1).
- `pop = m_valid && m_ready`.
- `fifo_rd = en && !fifo_empty && (count + pending - pop) < 2`. Never asserted while `rst` is high.
- Read in flight: `pending` is set to `fifo_rd` each cycle. While `pending`=1, `fifo_dout` is written into the tail entry at the clock edge.
- Invariant: `count + pending ≤ 2`. The buffer never overflows and no fetched word is dropped.
- `m_valid = (count != 0)`. `m_data` is the head entry. FIFO order is preserved.
- Simultaneous push and pop: `count` is unchanged, head advances, tail advances.
- Once `m_valid` is high, `m_data` and `m_last` hold until `pop`.
- Framing:
  - `m_last = m_valid && (beat == pkt_len-1)`.
  - `beat` increments on `pop` and wraps to 0 after `pkt_len-1`.
  - When `pkt_len`=1, `m_last` equals `m_valid`.
- `en` low: no new reads. The pending word and buffered words still drain normally. `beat` is preserved across `en` toggles.
- FIFO empty: no read is issued. Buffered words still drain.
- Reset (any cycle, including mid-packet): `pending`=0, `count`=0, head/tail=0, `beat`=0.
  - A word in flight at reset is discarded, so the FIFO must be reset together with this block.

## Timing
- Reset values: `fifo_rd`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- Latency: `fifo_rd` high in cycle N → `fifo_dout` valid in N+1 → `m_valid` high in N+2.
- First-word latency from `fifo_empty` falling (with `en`=1 and buffer empty) is 2 cycles.
- Throughput: 1 word/cycle when `m_ready` is held high and the FIFO stays non-empty.
- Backpressure: with `m_ready` low, at most 2 further words are fetched and then `fifo_rd` stays low.
  - After `m_ready` rises, reads resume in the same cycle, because `pop` enters the `fifo_rd` term.
- Paths: the only combinational path from inputs to outputs is `en`/`fifo_empty`/`m_ready` → `fifo_rd`. `m_valid`, `m_data` and `m_last` come from registers only.

## Configuration
- `FIFO_STREAM_READER_STATS_EN`: when defined, adds two outputs, both reset to 0 and both wrapping at 2^32:
  - `word_cnt` [31:0]: increments on every `pop`.
  - `pkt_cnt` [31:0]: increments on every `pop` with `m_last`.
- When undefined, both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then FIFO holds 0x11,0x22,0x33 and `m_ready`=1 → `fifo_rd` high for 3 cycles; `m_data` shows 0x11,0x22,0x33 on consecutive cycles, starting 2 cycles after the first read; then `m_valid`=0.
- 8 words with `pkt_len`=4 and `m_ready`=1 → `m_last` high on words 4 and 8 only; with STATS, `word_cnt`=8 and `pkt_cnt`=2.
- 5 words queued with `m_ready`=0 for 10 cycles → exactly 2 reads issued, `m_valid`=1, `m_data`=word0 stable. Then `m_ready`=1 → all 5 words arrive in order with no gaps.
- Toggle `m_ready` 1,0,1,0 with 6 words queued → each word is delivered exactly once and in order; `count` never exceeds 2.
- `en` dropped for 5 cycles mid-stream after word 2 of a 4-word packet → no reads while `en` is low; buffered words drain; `beat` resumes so that the 4th delivered word carries `m_last`.
- `rst` pulsed for 1 cycle with 2 words buffered → next cycle `m_valid`=0, `fifo_rd`=0, `beat`=0, and the STATS counters are 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (rd/empty/dout) into a valid/ready stream with m_last framing.
// Latency: fifo_rd in cycle N, fifo_dout in N+1, m_valid in N+2; one word per cycle under continuous m_ready.
// Backpressure: with m_ready low at most two words are fetched into the buffer, then fifo_rd stays low.
// Optional feature macro: FIFO_STREAM_READER_STATS_EN adds word_cnt/pkt_cnt outputs.
module fifo_stream_reader #(
   parameter int width   = 8,
   parameter int pkt_len = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_dout,
   output logic             fifo_rd,
   output logic             m_valid,
   output logic [width-1:0] m_data,
   output logic             m_last,
   input  logic             m_ready
`ifdef FIFO_STREAM_READER_STATS_EN
   ,
   output logic [31:0]      word_cnt,
   output logic [31:0]      pkt_cnt
`endif
);

   // beat counter needs at least one bit even for single-word packets
   localparam int bw = (pkt_len > 1) ? $clog2(pkt_len) : 1;
   localparam logic [bw-1:0] beat_max = bw'(pkt_len - 1);

   logic             pending;
   logic [1:0]       count;
   logic             head;
   logic             tail;
   logic [width-1:0] buf_q [2];
   logic [bw-1:0]    beat;
   logic             pop;
   logic [1:0]       occ_after_pop;

   // read request: only when the buffer can absorb the word returning next cycle
   always_comb begin
      pop           = m_valid && m_ready;
      occ_after_pop = count + {1'b0, pending} - {1'b0, pop};
      fifo_rd       = !rst && en && !fifo_empty && (occ_after_pop < 2'd2);
   end

   // outputs come straight from buffer registers; head selects the oldest word
   assign m_valid = (count != 2'd0);
   assign m_data  = buf_q[head];
   assign m_last  = m_valid && (beat == beat_max);

   // buffer, occupancy, in-flight flag and packet beat tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= 1'b0;
         count    <= 2'd0;
         head     <= 1'b0;
         tail     <= 1'b0;
         beat     <= '0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         pending <= fifo_rd;
         count   <= occ_after_pop + {1'b0, pending} - {1'b0, pending} ;
         if (pending) begin
            buf_q[tail] <= fifo_dout;
            tail        <= ~tail;
         end
         if (pop) begin
            head <= ~head;
            beat <= (beat == beat_max) ? '0 : beat + 1'b1;
         end
      end
   end

`ifdef FIFO_STREAM_READER_STATS_EN
   // delivered word and packet counters, free-running with 32-bit wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt <= '0;
         pkt_cnt  <= '0;
      end else if (pop) begin
         word_cnt <= word_cnt + 32'd1;
         if (m_last) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: behavioural FIFO plus reference model checking fifo_stream_reader.
// Latency: model expects each read word to become visible two cycles after its fifo_rd.
// Backpressure: m_ready driven by directed patterns and randomly.
module tb_fifo_stream_reader;
   localparam int W   = 8;
   localparam int PKT = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_dout = '0;
   logic         fifo_rd;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_last;
   logic         m_ready = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
   logic [31:0]  word_cnt;
   logic [31:0]  pkt_cnt;
`endif

   fifo_stream_reader #(.width(W), .pkt_len(PKT)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd(fifo_rd), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
`ifdef FIFO_STREAM_READER_STATS_EN
      , .word_cnt(word_cnt), .pkt_cnt(pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   // simple synchronous FIFO: dout valid the cycle after rd
   logic [W-1:0] fq [$];
   always @(posedge clk) begin
      if (rst) fifo_dout <= '0;
      else if (fifo_rd && fq.size() != 0) fifo_dout <= fq.pop_front();
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // reference model state
   logic [W-1:0] exp_q [$];   // every word pushed, in delivery order
   int rdcyc [$];             // cycle of each outstanding read
   int cyc_no = 0;
   int pk_idx = 0;
   int tot_pop = 0;
   int tot_pkt = 0;
   // per-scenario window statistics
   int win_rd, win_pop, win_last, first_rd, first_pop, last_pop;

   task automatic win_clear();
      win_rd = 0; win_pop = 0; win_last = 0;
      first_rd = -1; first_pop = -1; last_pop = -1;
   endtask

   task automatic push(input logic [W-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic cyc(input logic r, input logic e, input logic rdy);
      logic exp_vld, exp_rd, p;
      @(negedge clk);
      rst = r; en = e; m_ready = rdy;
      fifo_empty = (fq.size() == 0);
      #1;
      if (r) begin
         chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
         fq.delete(); exp_q.delete(); rdcyc.delete();
         pk_idx = 0; tot_pop = 0; tot_pkt = 0;
      end else begin
`ifdef FIFO_STREAM_READER_STATS_EN
         chk("word_cnt", word_cnt, tot_pop);
         chk("pkt_cnt", pkt_cnt, tot_pkt);
`endif
         exp_vld = (rdcyc.size() > 0) && (rdcyc[0] + 2 <= cyc_no);
         chk("m_valid", {31'd0, m_valid}, {31'd0, exp_vld});
         if (exp_vld && exp_q.size() > 0) begin
            chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
            chk("m_last", {31'd0, m_last}, {31'd0, pk_idx == PKT - 1});
         end
         p = exp_vld && rdy;
         exp_rd = e && (fq.size() > 0) && ((rdcyc.size() - int'(p)) < 2);
         chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
         if (p) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            void'(rdcyc.pop_front());
            if (pk_idx == PKT - 1) begin tot_pkt++; win_last++; end
            pk_idx = (pk_idx + 1) % PKT;
            tot_pop++; win_pop++;
            if (first_pop < 0) first_pop = cyc_no;
            last_pop = cyc_no;
         end
         if (fifo_rd) begin
            rdcyc.push_back(cyc_no);
            win_rd++;
            if (first_rd < 0) first_rd = cyc_no;
         end
         if (rdcyc.size() > 2) chk("occupancy", rdcyc.size(), 2);
      end
      cyc_no++;
   endtask

   initial begin
      int n;
      win_clear();
      // reset with a non-empty FIFO: no read may be issued
      push(8'h55); push(8'h66);
      cyc(1, 1, 1);
      cyc(0, 0, 0);
      chk("init_valid", {31'd0, m_valid}, 32'd0);
      chk("init_data", {24'd0, m_data}, 32'd0);
      chk("init_last", {31'd0, m_last}, 32'd0);
      chk("init_rd", {31'd0, fifo_rd}, 32'd0);

      // three words, continuous ready
      push(8'h11); push(8'h22); push(8'h33);
      win_clear();
      for (int i = 0; i < 8; i++) cyc(0, 1, 1);
      chk("t1_reads", win_rd, 3);
      chk("t1_latency", first_pop - first_rd, 2);
      chk("t1_b2b", last_pop - first_pop, 2);
      chk("t1_idle", {31'd0, m_valid}, 32'd0);

      // two packets of four
      cyc(1, 0, 0);
      for (int i = 0; i < 8; i++) push(W'(8'h40 + i));
      win_clear();
      for (int i = 0; i < 12; i++) cyc(0, 1, 1);
      chk("t2_pops", win_pop, 8);
      chk("t2_lasts", win_last, 2);

      // stall: exactly two fetched, head word held
      cyc(1, 0, 0);
      for (int i = 0; i < 5; i++) push(W'(8'hA0 + i));
      win_clear();
      for (int i = 0; i < 10; i++) cyc(0, 1, 0);
      chk("t3_reads", win_rd, 2);
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_data", {24'd0, m_data}, 32'hA0);
      win_clear();
      for (int i = 0; i < 8; i++) cyc(0, 1, 1);
      chk("t3_pops", win_pop, 5);
      chk("t3_nogap", last_pop - first_pop, 4);

      // alternating ready
      cyc(1, 0, 0);
      for (int i = 0; i < 6; i++) push(W'(8'hC0 + i));
      win_clear();
      for (int i = 0; i < 20; i++) cyc(0, 1, (i % 2) == 0);
      chk("t4_pops", win_pop, 6);

      // en dropped after word 2 of a packet
      cyc(1, 0, 0);
      for (int i = 0; i < 8; i++) push(W'(8'hD0 + i));
      win_clear();
      n = 0;
      while (win_pop < 2 && n < 10) begin cyc(0, 1, 1); n++; end
      chk("t5_reach", {31'd0, win_pop >= 2}, 32'd1);
      n = win_rd;
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);
      chk("t5_no_rd", win_rd - n, 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1);
      chk("t5_pops", win_pop, 8);
      chk("t5_lasts", win_last, 2);

      // reset with two words buffered
      cyc(1, 0, 0);
      for (int i = 0; i < 5; i++) push(W'(8'hE0 + i));
      for (int i = 0; i < 6; i++) cyc(0, 1, 0);
      chk("t6_buffered", {31'd0, m_valid}, 32'd1);
      cyc(1, 1, 0);
      cyc(0, 1, 0);
      chk("t6_valid", {31'd0, m_valid}, 32'd0);
      chk("t6_rd", {31'd0, fifo_rd}, 32'd0);
      chk("t6_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
      chk("t6_wcnt", word_cnt, 32'd0);
      chk("t6_pcnt", pkt_cnt, 32'd0);
`endif
      for (int i = 0; i < 4; i++) push(W'(8'hF0 + i));
      win_clear();
      for (int i = 0; i < 8; i++) cyc(0, 1, 1);
      chk("t6_beat", win_last, 1);

      // randomized traffic with occasional reset
      for (int i = 0; i < 2000; i++) begin
         if (fq.size() < 6 && $urandom_range(0, 2) != 0) push(W'($urandom));
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 30; i++) cyc(0, 1, 1);
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
